mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage: the producer side of the MEM/WB interface that the writeback stage consumes.
- Accepts one instruction at a time from EX and issues data-SRAM requests for loads and stores on an SRAM-like addr_ok/data_ok handshake.
- Aligns and extends load data, then registers the complete MEM/WB bundle (control, address, PC, read data, HI/LO) for WB.
- WB never stalls; backpressure to EX comes only from outstanding memory transactions.

Parameters:
- None; data width is fixed at 32, register address at 5.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
valid_EX_MEM  in  1  EX presents an instruction
allowin_MEM  out  1  MEM accepts this cycle; transfer = valid_EX_MEM & allowin_MEM
MemRead_EX_MEM  in  1  load
MemWrite_EX_MEM  in  1  store
LoadType_EX_MEM  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
StoreType_EX_MEM  in  2  0 SW, 1 SB, 2 SH
MemToReg_EX_MEM  in  1  passed to WB
RegWrite_EX_MEM  in  4  byte write enables, passed to WB
MFHL_EX_MEM  in  2  passed to WB
RegWaddr_EX_MEM  in  5  destination register
ALUResult_EX_MEM  in  32  result or effective address
PC_EX_MEM  in  32  instruction PC
MemWdata_EX_MEM  in  32  store data, low-aligned
HI_EX_MEM, LO_EX_MEM  in  32 each  HI/LO values
data_req  out  1  SRAM request
data_wr  out  1  1 = write
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  byte address
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data / write response
data_rdata  in  32  raw read word
valid_MEM_WB  out  1  WB bundle valid
MemToReg_MEM_WB  out  1
RegWrite_MEM_WB  out  4  forced 0 when valid_MEM_WB = 0
MFHL_MEM_WB  out  2
RegWaddr_MEM_WB  out  5
ALUResult_MEM_WB, PC_MEM_WB, MemRdata_MEM_WB, HI_MEM_WB, LO_MEM_WB  out  32 each

Behaviour:
- Reset (reset = 0 at clk edge): state IDLE; all MEM_WB outputs and the internal instruction latch set to 0; data_req = 0. Reset mid-transaction abandons it; no WB push.
- FSM states:
  - IDLE: allowin_MEM = 1. On transfer, all EX fields are latched.
    - Non-memory op: pushed to the WB register at the same edge (1-cycle latency); stays IDLE.
    - Load or store: go to ADDR.
  - ADDR: data_req = 1; data_addr, data_wr, data_size and data_wdata are driven from the latch and held stable until addr_ok.
    - addr_ok = 1, data_ok = 0: go to DATA.
    - addr_ok = 1 and data_ok = 1 in the same cycle: complete directly to IDLE.
  - DATA: data_req = 0. On data_ok: push to WB, go IDLE.
- allowin_MEM = 0 in ADDR and DATA.
- data_data_ok is ignored in IDLE, so stale responses after reset are dropped.
- WB push:
  - valid_MEM_WB = 1 for exactly one cycle per instruction; fields hold until the next push.
  - Cycles with no push: valid_MEM_WB = 0 and RegWrite_MEM_WB = 0.
  - Stores push with RegWrite_MEM_WB = 0 and MemRdata_MEM_WB = 0.
- Load formatting uses lane = addr[1:0] and is registered into MemRdata_MEM_WB at the push edge:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: whole word.
- Store encoding: data_size = 0/1/2 for SB/SH/SW; data_wdata = {4{b}}, {2{h}} or the word; data_addr = ALUResult unmodified.
- Alignment exceptions are raised in EX; misaligned addresses are forwarded unchanged.
- The latched request never changes while in ADDR or DATA.

Test Plan:
- ADD, ALUResult = 0x1234, RegWaddr = 5, RegWrite = 4'hF, accepted in IDLE -> next cycle valid_MEM_WB = 1 with matching fields; the cycle after, RegWrite_MEM_WB = 0.
- LB at 0x1002, rdata = 0x00A50000, addr_ok after 2 cycles, data_ok after 3 more -> data_size = 0; allowin_MEM = 0 throughout; MemRdata_MEM_WB = 0xFFFFFFA5 the cycle after data_ok.
- LHU at 0x2002, rdata = 0x8001FFFF, addr_ok and data_ok in the same cycle -> MemRdata_MEM_WB = 0x00008001; IDLE next cycle.
- SB at 0x3001, wdata = 0x000000CC -> data_wr = 1, data_size = 0, data_wdata = 0xCCCCCCCC; push has RegWrite_MEM_WB = 0.
- reset = 0 while in DATA, then data_ok arrives 2 cycles after release -> no WB push, data_req = 0, allowin_MEM = 1.
- MFHL = 2'b10 with HI = 0xDEAD0000 passes through -> HI_MEM_WB = 0xDEAD0000 and MFHL_MEM_WB = 2'b10 on the push cycle.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches one EX instruction, runs its data-SRAM access, registers the MEM/WB bundle.
// Latency: non-memory ops 1 cycle (push at accept edge); loads/stores push at the data_ok edge.
// Backpressure: allowin_MEM drops while a memory access is outstanding; WB never stalls.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-low reset
//   *_EX_MEM / allowin   - EX -> MEM instruction bundle with valid/allowin handshake
//   data_*               - SRAM-like request channel (req/addr_ok) and response (data_ok/rdata)
//   *_MEM_WB             - registered MEM -> WB bundle, valid for one cycle per instruction
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_EX_MEM,
    output logic        allowin_MEM,
    input  logic        MemRead_EX_MEM,
    input  logic        MemWrite_EX_MEM,
    input  logic [2:0]  LoadType_EX_MEM,
    input  logic [1:0]  StoreType_EX_MEM,
    input  logic        MemToReg_EX_MEM,
    input  logic [3:0]  RegWrite_EX_MEM,
    input  logic [1:0]  MFHL_EX_MEM,
    input  logic [4:0]  RegWaddr_EX_MEM,
    input  logic [31:0] ALUResult_EX_MEM,
    input  logic [31:0] PC_EX_MEM,
    input  logic [31:0] MemWdata_EX_MEM,
    input  logic [31:0] HI_EX_MEM,
    input  logic [31:0] LO_EX_MEM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        valid_MEM_WB,
    output logic        MemToReg_MEM_WB,
    output logic [3:0]  RegWrite_MEM_WB,
    output logic [1:0]  MFHL_MEM_WB,
    output logic [4:0]  RegWaddr_MEM_WB,
    output logic [31:0] ALUResult_MEM_WB,
    output logic [31:0] PC_MEM_WB,
    output logic [31:0] MemRdata_MEM_WB,
    output logic [31:0] HI_MEM_WB,
    output logic [31:0] LO_MEM_WB
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Instruction latch: held constant for the whole memory access.
    logic        mem_read_q;
    logic        mem_write_q;
    logic [2:0]  load_type_q;
    logic [1:0]  store_type_q;
    logic        mem_to_reg_q;
    logic [3:0]  reg_write_q;
    logic [1:0]  mfhl_q;
    logic [4:0]  waddr_q;
    logic [31:0] alu_q;
    logic [31:0] pc_q;
    logic [31:0] wdata_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // MEM/WB output registers.
    logic        wb_vld_q,        wb_vld_d;
    logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [3:0]  wb_reg_write_q,  wb_reg_write_d;
    logic [1:0]  wb_mfhl_q,       wb_mfhl_d;
    logic [4:0]  wb_waddr_q,      wb_waddr_d;
    logic [31:0] wb_alu_q,        wb_alu_d;
    logic [31:0] wb_pc_q,         wb_pc_d;
    logic [31:0] wb_rdata_q,      wb_rdata_d;
    logic [31:0] wb_hi_q,         wb_hi_d;
    logic [31:0] wb_lo_q,         wb_lo_d;

    logic        transfer;
    logic        is_mem_in;
    logic        push_alu;
    logic        push_mem;
    logic        is_load_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;

    assign transfer  = valid_EX_MEM & allowin_MEM;
    assign is_mem_in = MemRead_EX_MEM | MemWrite_EX_MEM;
    // Non-memory ops bypass the latch and go straight into the WB register.
    assign push_alu  = transfer & ~is_mem_in;
    // A store flagged as both read and write is treated as a store.
    assign is_load_q = mem_read_q & ~mem_write_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        allowin_MEM = 1'b0;
        data_req    = 1'b0;
        push_mem    = 1'b0;
        case (state_q)
            S_IDLE: begin
                allowin_MEM = 1'b1;
                // data_data_ok is deliberately ignored here: responses to an
                // access abandoned by reset must not produce a push.
                if (valid_EX_MEM && is_mem_in) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                data_req = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        push_mem = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (data_data_ok) begin
                    push_mem = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            load_type_q  <= 3'd0;
            store_type_q <= 2'd0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 4'd0;
            mfhl_q       <= 2'd0;
            waddr_q      <= 5'd0;
            alu_q        <= 32'd0;
            pc_q         <= 32'd0;
            wdata_q      <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else if (transfer) begin
            mem_read_q   <= MemRead_EX_MEM;
            mem_write_q  <= MemWrite_EX_MEM;
            load_type_q  <= LoadType_EX_MEM;
            store_type_q <= StoreType_EX_MEM;
            mem_to_reg_q <= MemToReg_EX_MEM;
            reg_write_q  <= RegWrite_EX_MEM;
            mfhl_q       <= MFHL_EX_MEM;
            waddr_q      <= RegWaddr_EX_MEM;
            alu_q        <= ALUResult_EX_MEM;
            pc_q         <= PC_EX_MEM;
            wdata_q      <= MemWdata_EX_MEM;
            hi_q         <= HI_EX_MEM;
            lo_q         <= LO_EX_MEM;
        end
    end

    // ------------------------------------------------------------------
    // SRAM request encoding (driven from the latch, so stable until addr_ok)
    // ------------------------------------------------------------------
    assign data_wr   = mem_write_q;
    assign data_addr = alu_q;

    always_comb begin
        data_size  = 2'd2;
        data_wdata = wdata_q;
        if (mem_write_q) begin
            // Replicate the low-aligned store data into every lane so the
            // SRAM picks the right bytes from the address alone.
            case (store_type_q)
                2'd1: begin
                    data_size  = 2'd0;
                    data_wdata = {4{wdata_q[7:0]}};
                end
                2'd2: begin
                    data_size  = 2'd1;
                    data_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    data_size  = 2'd2;
                    data_wdata = wdata_q;
                end
            endcase
        end else begin
            case (load_type_q)
                3'd1, 3'd2: data_size = 2'd0;
                3'd3, 3'd4: data_size = 2'd1;
                default:    data_size = 2'd2;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load alignment / extension
    // ------------------------------------------------------------------
    always_comb begin
        case (alu_q[1:0])
            2'd0:    ld_byte = data_rdata[7:0];
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        // Misaligned halves are not trapped here; addr[1] alone picks the half.
        ld_half = alu_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (load_type_q)
            3'd1:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    load_fmt = {24'd0, ld_byte};
            3'd3:    load_fmt = {{16{ld_half[15]}}, ld_half};
            3'd4:    load_fmt = {16'd0, ld_half};
            default: load_fmt = data_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_comb begin
        wb_vld_d        = push_alu | push_mem;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mfhl_d       = wb_mfhl_q;
        wb_waddr_d      = wb_waddr_q;
        wb_alu_d        = wb_alu_q;
        wb_pc_d         = wb_pc_q;
        wb_rdata_d      = wb_rdata_q;
        wb_hi_d         = wb_hi_q;
        wb_lo_d         = wb_lo_q;
        if (push_alu) begin
            wb_mem_to_reg_d = MemToReg_EX_MEM;
            wb_reg_write_d  = RegWrite_EX_MEM;
            wb_mfhl_d       = MFHL_EX_MEM;
            wb_waddr_d      = RegWaddr_EX_MEM;
            wb_alu_d        = ALUResult_EX_MEM;
            wb_pc_d         = PC_EX_MEM;
            wb_rdata_d      = 32'd0;
            wb_hi_d         = HI_EX_MEM;
            wb_lo_d         = LO_EX_MEM;
        end else if (push_mem) begin
            wb_mem_to_reg_d = mem_to_reg_q;
            wb_reg_write_d  = is_load_q ? reg_write_q : 4'd0;
            wb_mfhl_d       = mfhl_q;
            wb_waddr_d      = waddr_q;
            wb_alu_d        = alu_q;
            wb_pc_d         = pc_q;
            wb_rdata_d      = is_load_q ? load_fmt : 32'd0;
            wb_hi_d         = hi_q;
            wb_lo_d         = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_vld_q        <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 4'd0;
            wb_mfhl_q       <= 2'd0;
            wb_waddr_q      <= 5'd0;
            wb_alu_q        <= 32'd0;
            wb_pc_q         <= 32'd0;
            wb_rdata_q      <= 32'd0;
            wb_hi_q         <= 32'd0;
            wb_lo_q         <= 32'd0;
        end else begin
            wb_vld_q        <= wb_vld_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mfhl_q       <= wb_mfhl_d;
            wb_waddr_q      <= wb_waddr_d;
            wb_alu_q        <= wb_alu_d;
            wb_pc_q         <= wb_pc_d;
            wb_rdata_q      <= wb_rdata_d;
            wb_hi_q         <= wb_hi_d;
            wb_lo_q         <= wb_lo_d;
        end
    end

    assign valid_MEM_WB     = wb_vld_q;
    // Fields hold between pushes, but write enables must not leak into WB.
    assign RegWrite_MEM_WB  = wb_vld_q ? wb_reg_write_q : 4'd0;
    assign MemToReg_MEM_WB  = wb_mem_to_reg_q;
    assign MFHL_MEM_WB      = wb_mfhl_q;
    assign RegWaddr_MEM_WB  = wb_waddr_q;
    assign ALUResult_MEM_WB = wb_alu_q;
    assign PC_MEM_WB        = wb_pc_q;
    assign MemRdata_MEM_WB  = wb_rdata_q;
    assign HI_MEM_WB        = wb_hi_q;
    assign LO_MEM_WB        = wb_lo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, reset-abandon sequence, randomized traffic vs model.
// Latency: checks the push one cycle after accept (ALU) or after data_ok (memory ops).
// Backpressure: checks allowin_MEM low and request stability while an access is outstanding.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid_EX_MEM;
    logic        allowin_MEM;
    logic        MemRead_EX_MEM;
    logic        MemWrite_EX_MEM;
    logic [2:0]  LoadType_EX_MEM;
    logic [1:0]  StoreType_EX_MEM;
    logic        MemToReg_EX_MEM;
    logic [3:0]  RegWrite_EX_MEM;
    logic [1:0]  MFHL_EX_MEM;
    logic [4:0]  RegWaddr_EX_MEM;
    logic [31:0] ALUResult_EX_MEM;
    logic [31:0] PC_EX_MEM;
    logic [31:0] MemWdata_EX_MEM;
    logic [31:0] HI_EX_MEM;
    logic [31:0] LO_EX_MEM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        valid_MEM_WB;
    logic        MemToReg_MEM_WB;
    logic [3:0]  RegWrite_MEM_WB;
    logic [1:0]  MFHL_MEM_WB;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [31:0] ALUResult_MEM_WB;
    logic [31:0] PC_MEM_WB;
    logic [31:0] MemRdata_MEM_WB;
    logic [31:0] HI_MEM_WB;
    logic [31:0] LO_MEM_WB;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .valid_EX_MEM(valid_EX_MEM), .allowin_MEM(allowin_MEM),
        .MemRead_EX_MEM(MemRead_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
        .LoadType_EX_MEM(LoadType_EX_MEM), .StoreType_EX_MEM(StoreType_EX_MEM),
        .MemToReg_EX_MEM(MemToReg_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM),
        .MFHL_EX_MEM(MFHL_EX_MEM), .RegWaddr_EX_MEM(RegWaddr_EX_MEM),
        .ALUResult_EX_MEM(ALUResult_EX_MEM), .PC_EX_MEM(PC_EX_MEM),
        .MemWdata_EX_MEM(MemWdata_EX_MEM), .HI_EX_MEM(HI_EX_MEM), .LO_EX_MEM(LO_EX_MEM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .valid_MEM_WB(valid_MEM_WB), .MemToReg_MEM_WB(MemToReg_MEM_WB),
        .RegWrite_MEM_WB(RegWrite_MEM_WB), .MFHL_MEM_WB(MFHL_MEM_WB),
        .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .ALUResult_MEM_WB(ALUResult_MEM_WB),
        .PC_MEM_WB(PC_MEM_WB), .MemRdata_MEM_WB(MemRdata_MEM_WB),
        .HI_MEM_WB(HI_MEM_WB), .LO_MEM_WB(LO_MEM_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct {
        int          kind;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] hi;
        logic [1:0]  mfhl;
        logic [4:0]  waddr;
        logic [3:0]  rw;
        int          ao;      // cycles in ADDR before addr_ok
        int          dd;      // cycles after the addr_ok cycle until data_ok (0 = same cycle)
        logic [1:0]  e_size;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model (arithmetic on the byte-lane rules) --------------
    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] val;
        case (lt)
            3'd1, 3'd2: begin
                val = (d >> (8 * (a % 4))) % 256;
                if (lt == 3'd1 && val >= 128) val = val - 32'd256;
            end
            3'd3, 3'd4: begin
                val = (d >> (16 * ((a / 2) % 2))) % 65536;
                if (lt == 3'd3 && val >= 32768) val = val - 32'd65536;
            end
            default: val = d;
        endcase
        return val;
    endfunction

    function automatic logic [1:0] m_size(input int kind, input logic [2:0] lt, input logic [1:0] st);
        if (kind == 2) return (st == 2'd1) ? 2'd0 : (st == 2'd2) ? 2'd1 : 2'd2;
        return (lt == 3'd0) ? 2'd2 : (lt <= 3'd2) ? 2'd0 : 2'd1;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] w);
        if (st == 2'd1) return (w % 256) * 32'h0101_0101;
        if (st == 2'd2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    task automatic clear_inputs();
        valid_EX_MEM = 0; MemRead_EX_MEM = 0; MemWrite_EX_MEM = 0;
        LoadType_EX_MEM = 0; StoreType_EX_MEM = 0; MemToReg_EX_MEM = 0;
        RegWrite_EX_MEM = 0; MFHL_EX_MEM = 0; RegWaddr_EX_MEM = 0;
        ALUResult_EX_MEM = 0; PC_EX_MEM = 0; MemWdata_EX_MEM = 0;
        HI_EX_MEM = 0; LO_EX_MEM = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    // Present v, run its memory access and check the push. Entry/exit: IDLE, #1 after posedge.
    task automatic do_txn(input vec_t v, input logic [31:0] pc);
        logic [3:0] exp_rw;
        exp_rw = (v.kind == 2) ? 4'd0 : v.rw;
        valid_EX_MEM     = 1;
        MemRead_EX_MEM   = (v.kind == 1);
        MemWrite_EX_MEM  = (v.kind == 2);
        LoadType_EX_MEM  = v.lt;
        StoreType_EX_MEM = v.st;
        MemToReg_EX_MEM  = (v.kind == 1);
        RegWrite_EX_MEM  = v.rw;
        MFHL_EX_MEM      = v.mfhl;
        RegWaddr_EX_MEM  = v.waddr;
        ALUResult_EX_MEM = v.addr;
        PC_EX_MEM        = pc;
        MemWdata_EX_MEM  = v.wdata;
        HI_EX_MEM        = v.hi;
        LO_EX_MEM        = ~v.hi;
        @(negedge clk);
        chk("allowin_idle", allowin_MEM, 1);
        @(posedge clk); #1;
        // Scramble EX inputs: the stage must work from its latch from now on.
        valid_EX_MEM = 0;
        ALUResult_EX_MEM = $urandom; MemWdata_EX_MEM = $urandom; PC_EX_MEM = $urandom;
        LoadType_EX_MEM = 3'($urandom_range(0, 4)); StoreType_EX_MEM = 2'($urandom_range(0, 2));
        HI_EX_MEM = $urandom; LO_EX_MEM = $urandom; RegWrite_EX_MEM = 4'($urandom);
        if (v.kind != 0) begin
            for (int i = 0; i <= v.ao; i++) begin
                if (i == v.ao) begin
                    data_addr_ok = 1;
                    if (v.dd == 0) begin data_data_ok = 1; data_rdata = v.rdata; end
                end
                @(negedge clk);
                chk("addr_req", data_req, 1);
                chk("addr_allowin", allowin_MEM, 0);
                chk("addr_addr", data_addr, v.addr);
                chk("addr_wr", data_wr, (v.kind == 2));
                chk("addr_size", data_size, v.e_size);
                if (v.kind == 2) chk("addr_wdata", data_wdata, v.e_wdata);
                @(posedge clk); #1;
                data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
            end
            for (int i = 1; i <= v.dd; i++) begin
                if (i == v.dd) begin data_data_ok = 1; data_rdata = v.rdata; end
                @(negedge clk);
                chk("data_req", data_req, 0);
                chk("data_allowin", allowin_MEM, 0);
                chk("data_novalid", valid_MEM_WB, 0);
                @(posedge clk); #1;
                data_data_ok = 0; data_rdata = $urandom;
            end
        end
        @(negedge clk);
        chk("push_valid", valid_MEM_WB, 1);
        chk("push_regwrite", RegWrite_MEM_WB, exp_rw);
        chk("push_alu", ALUResult_MEM_WB, v.addr);
        chk("push_pc", PC_MEM_WB, pc);
        chk("push_waddr", RegWaddr_MEM_WB, v.waddr);
        chk("push_memtoreg", MemToReg_MEM_WB, (v.kind == 1));
        chk("push_mfhl", MFHL_MEM_WB, v.mfhl);
        chk("push_hi", HI_MEM_WB, v.hi);
        chk("push_lo", LO_MEM_WB, ~v.hi);
        if (v.kind == 1) chk("push_rdata", MemRdata_MEM_WB, v.e_rdata);
        if (v.kind == 2) chk("push_rdata_st", MemRdata_MEM_WB, 0);
        chk("push_allowin", allowin_MEM, 1);
        chk("push_req", data_req, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_valid", valid_MEM_WB, 0);
        chk("post_regwrite", RegWrite_MEM_WB, 0);
        chk("post_hold_alu", ALUResult_MEM_WB, v.addr);
        @(posedge clk); #1;
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        //           kind lt    st    addr          wdata         rdata         hi            mfhl   wa  rw     ao dd size  e_wdata       e_rdata
        tbl[0] = '{0, 3'd0, 2'd0, 32'h0000_1234, 32'h0,        32'h0,        32'h1111_2222, 2'b00, 5, 4'hF, 0, 0, 2'd2, 32'h0,        32'h0};
        tbl[1] = '{1, 3'd1, 2'd0, 32'h0000_1002, 32'h0,        32'h00A5_0000, 32'h0,        2'b00, 7, 4'hF, 2, 3, 2'd0, 32'h0,        32'hFFFF_FFA5};
        tbl[2] = '{1, 3'd4, 2'd0, 32'h0000_2002, 32'h0,        32'h8001_FFFF, 32'h0,        2'b00, 8, 4'hF, 1, 0, 2'd1, 32'h0,        32'h0000_8001};
        tbl[3] = '{2, 3'd0, 2'd1, 32'h0000_3001, 32'h0000_00CC, 32'h0,       32'h0,        2'b00, 9, 4'hF, 0, 1, 2'd0, 32'hCCCC_CCCC, 32'h0};
        tbl[4] = '{0, 3'd0, 2'd0, 32'h0000_0040, 32'h0,        32'h0,        32'hDEAD_0000, 2'b10, 3, 4'hF, 0, 0, 2'd2, 32'h0,        32'h0};
        tbl[5] = '{1, 3'd0, 2'd0, 32'h0000_4000, 32'h0,        32'h1234_5678, 32'h0,        2'b00, 10, 4'hF, 0, 1, 2'd2, 32'h0,       32'h1234_5678};
        tbl[6] = '{1, 3'd3, 2'd0, 32'h0000_5000, 32'h0,        32'h0000_F00F, 32'h0,        2'b00, 11, 4'h3, 1, 0, 2'd1, 32'h0,       32'hFFFF_F00F};
        tbl[7] = '{2, 3'd0, 2'd2, 32'h0000_6002, 32'h0000_BEEF, 32'h0,       32'h0,        2'b00, 12, 4'hF, 3, 2, 2'd1, 32'hBEEF_BEEF, 32'h0};
        tbl[8] = '{2, 3'd0, 2'd0, 32'h0000_7000, 32'hA5A5_0F0F, 32'h0,       32'h0,        2'b00, 13, 4'hF, 0, 0, 2'd2, 32'hA5A5_0F0F, 32'h0};
        tbl[9] = '{1, 3'd2, 2'd0, 32'h0000_8003, 32'h0,        32'h8000_0000, 32'h0,        2'b00, 14, 4'h1, 2, 1, 2'd0, 32'h0,       32'h0000_0080};

        clear_inputs();
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("rst_valid", valid_MEM_WB, 0);
        chk("rst_regwrite", RegWrite_MEM_WB, 0);
        chk("rst_req", data_req, 0);
        chk("rst_allowin", allowin_MEM, 1);
        chk("rst_alu", ALUResult_MEM_WB, 0);
        chk("rst_pc", PC_MEM_WB, 0);
        chk("rst_rdata", MemRdata_MEM_WB, 0);
        chk("rst_hi", HI_MEM_WB, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_txn(tbl[i], 32'h0040_0000 + 32'(i) * 4);

        // Reset while in DATA: the late response must be dropped.
        valid_EX_MEM = 1; MemRead_EX_MEM = 1; MemToReg_EX_MEM = 1; LoadType_EX_MEM = 3'd0;
        RegWrite_EX_MEM = 4'hF; RegWaddr_EX_MEM = 5'd20; ALUResult_EX_MEM = 32'h0000_9000;
        @(posedge clk); #1;
        valid_EX_MEM = 0; MemRead_EX_MEM = 0; data_addr_ok = 1;
        @(posedge clk); #1;
        data_addr_ok = 0;
        @(negedge clk);
        chk("abort_in_data", allowin_MEM, 0);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("abort_allowin", allowin_MEM, 1);
        chk("abort_req", data_req, 0);
        @(posedge clk); #1;
        data_data_ok = 1; data_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("abort_req_ok", data_req, 0);
        @(posedge clk); #1;
        data_data_ok = 0;
        @(negedge clk);
        chk("abort_no_push", valid_MEM_WB, 0);
        chk("abort_regwrite", RegWrite_MEM_WB, 0);
        chk("abort_rdata", MemRdata_MEM_WB, 0);
        chk("abort_allowin2", allowin_MEM, 1);
        @(posedge clk); #1;
        do_txn(tbl[0], 32'h0040_1000);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 60; i++) begin
            v.kind  = $urandom_range(0, 2);
            v.lt    = 3'($urandom_range(0, 4));
            v.st    = 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.hi    = $urandom;
            v.mfhl  = 2'($urandom);
            v.waddr = 5'($urandom);
            v.rw    = 4'($urandom);
            v.ao    = $urandom_range(0, 3);
            v.dd    = $urandom_range(0, 3);
            v.e_size  = m_size(v.kind, v.lt, v.st);
            v.e_wdata = m_wdata(v.st, v.wdata);
            v.e_rdata = m_load(v.lt, v.addr, v.rdata);
            do_txn(v, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
